ram_fifo: RTL

//   Synchronous first-word-fall-through FIFO that uses DualPortRam as its storage array.

---
 rtl/ram_fifo.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ram_fifo.sv
// ram_fifo: first-word-fall-through FIFO built on a dual-port RAM that has a
// registered read port. The RAM read address looks one pop ahead, so the head
// word is already on the RAM output when the consumer needs it. A one-word
// bypass register covers the case where the word being written is the word
// that must appear at the head on the next cycle.

// DualPortRam: one write port and one registered read port.
// A read and a write to the same address in one cycle return the old data.
module DualPortRam #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wAddr,
    input  logic [ADDR_WIDTH-1:0] rAddr,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Storage write and registered read; read-during-write yields the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wAddr] <= dataIn;
        end
        q <= mem[rAddr];
    end

endmodule

module ram_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wrValid,
    output logic                  wrReady,
    input  logic [DATA_WIDTH-1:0] wrData,
    output logic                  rdValid,
    input  logic                  rdReady,
    output logic [DATA_WIDTH-1:0] rdData,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int CW = ADDR_WIDTH + 1;
    // Occupancy value that means "completely full" (2**ADDR_WIDTH).
    localparam logic [CW-1:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

    // Architectural state.
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  bypass_sel_q, bypass_sel_d;
    logic [DATA_WIDTH-1:0] bypass_data_q, bypass_data_d;

    // Handshake and RAM hookup.
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] rd_ptr_next;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [DATA_WIDTH-1:0] ram_q;

    // Status outputs come straight from the occupancy register so they are
    // glitch-free and valid immediately after an asynchronous reset.
    assign wrReady = (count_q != DEPTH_C);
    assign rdValid = (count_q != '0);
    assign count   = count_q;

    // Head word: the bypass register wins when the head was written on the
    // same edge that the RAM was reading that address (RAM returned old data).
    assign rdData = bypass_sel_q ? bypass_data_q : ram_q;

    // Handshake events and the look-ahead read pointer.
    always_comb begin
        push        = wrValid & wrReady;
        pop         = rdValid & rdReady;
        rd_ptr_next = rd_ptr_q + ADDR_WIDTH'(pop);
        // A flush drops the push, so the RAM must not be written either.
        ram_we      = push & ~flush;
        // During a flush the read pointer returns to 0; read that address so
        // the RAM output tracks the new head position.
        ram_raddr   = flush ? '0 : rd_ptr_next;
    end

    // Next-state logic for pointers, occupancy and the bypass path.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        bypass_sel_d  = 1'b0;
        bypass_data_d = wrData;

        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            bypass_sel_d = 1'b0;
        end else begin
            rd_ptr_d = rd_ptr_next;
            if (push) begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            end
            // count + push - pop, written out to keep widths exact.
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            // The word being written lands exactly where the RAM is reading
            // this edge, so the RAM output will be stale: steer from bypass.
            bypass_sel_d = push & (wr_ptr_q == rd_ptr_next);
        end
    end

    // Control state register with asynchronous reset; RAM contents untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            bypass_sel_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            bypass_sel_q <= bypass_sel_d;
        end
    end

    // Bypass data capture; only meaningful while bypass_sel_q is set, so it
    // needs no reset.
    always_ff @(posedge clk) begin
        bypass_data_q <= bypass_data_d;
    end

    DualPortRam #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .wAddr  (wr_ptr_q),
        .rAddr  (ram_raddr),
        .dataIn (wrData),
        .q      (ram_q)
    );

endmodule
